// File: rtl/mips_pipe_hazard_unit_pkg.sv
// mips_pkg: shared encodings for the 5-stage pipe hazard unit.
//   - forwarding select codes (FWD_RF / FWD_EXMEM / FWD_MEMWB)
//   - memory-wait FSM state codes (ST_RUN / ST_MEM_WAIT)
//   - default register index width
// Optional feature macro used by the users of this package: HAZ_PERF_CNT_EN.
package mips_pkg;

   localparam int unsigned REG_ADDR_W_DEF = 5;
   localparam int unsigned FWD_SEL_W      = 2;

   typedef enum logic [FWD_SEL_W-1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } hz_state_e;

endpackage : mips_pkg

// File: rtl/mips_pipe_hazard_unit_if.sv
// mips_pipe_hazard_unit_if: bundle between the pipeline datapath and the
// hazard unit.
//   master : datapath side, drives ID/EX operand info, br_taken, dmem_ack
//   slave  : hazard unit, drives dmem_req, stalls, flushes, forward selects,
//            pipe_frozen (and stall_cnt/flush_cnt when HAZ_PERF_CNT_EN is set)
// Parameters: REG_ADDR_W (register index width), CNT_W (only with
// HAZ_PERF_CNT_EN).
interface mips_pipe_hazard_unit_if
#(
   parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W_DEF
`ifdef HAZ_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W      = 16
`endif
);

   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rs;
   logic                  id_uses_rt;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_regwrite;
   logic                  id_memread;
   logic                  id_memwrite;
   logic [REG_ADDR_W-1:0] ex_rs;
   logic [REG_ADDR_W-1:0] ex_rt;
   logic                  br_taken;
   logic                  dmem_ack;

   logic                  dmem_req;
   logic                  stall_if;
   logic                  stall_id;
   logic                  flush_if_id;
   logic                  flush_id_ex;
   logic [1:0]            fwd_a_sel;
   logic [1:0]            fwd_b_sel;
   logic                  pipe_frozen;
`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      flush_cnt;
`endif

`ifdef HAZ_PERF_CNT_EN
   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
             id_regwrite, id_memread, id_memwrite, ex_rs, ex_rt, br_taken, dmem_ack,
      input  dmem_req, stall_if, stall_id, flush_if_id, flush_id_ex,
             fwd_a_sel, fwd_b_sel, pipe_frozen, stall_cnt, flush_cnt
   );
   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
             id_regwrite, id_memread, id_memwrite, ex_rs, ex_rt, br_taken, dmem_ack,
      output dmem_req, stall_if, stall_id, flush_if_id, flush_id_ex,
             fwd_a_sel, fwd_b_sel, pipe_frozen, stall_cnt, flush_cnt
   );
`else
   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
             id_regwrite, id_memread, id_memwrite, ex_rs, ex_rt, br_taken, dmem_ack,
      input  dmem_req, stall_if, stall_id, flush_if_id, flush_id_ex,
             fwd_a_sel, fwd_b_sel, pipe_frozen
   );
   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
             id_regwrite, id_memread, id_memwrite, ex_rs, ex_rt, br_taken, dmem_ack,
      output dmem_req, stall_if, stall_id, flush_if_id, flush_id_ex,
             fwd_a_sel, fwd_b_sel, pipe_frozen
   );
`endif

endinterface : mips_pipe_hazard_unit_if

// File: rtl/mips_pipe_hazard_unit_fwd_mux_sel.sv
// mips_fwd_mux_sel: forwarding comparator for one EX operand.
//   src_i          EX-stage source register index
//   mem_*_i        EX/MEM slot valid / regwrite / destination
//   wb_*_i         MEM/WB slot valid / regwrite / destination
//   sel_o          FWD_EXMEM if the MEM slot writes src, else FWD_MEMWB if the
//                  WB slot does, else FWD_RF; register 0 never forwards.
module mips_fwd_mux_sel
   import mips_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] src_i,
   input  logic                  mem_vld_i,
   input  logic                  mem_regwrite_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic                  wb_vld_i,
   input  logic                  wb_regwrite_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   output logic [FWD_SEL_W-1:0]  sel_o
);

   logic mem_hit;
   logic wb_hit;

   // Youngest producer wins, so the EX/MEM match is checked first.
   always_comb begin
      sel_o   = FWD_RF;
      mem_hit = mem_vld_i & mem_regwrite_i & (mem_rd_i != '0) & (mem_rd_i == src_i);
      wb_hit  = wb_vld_i & wb_regwrite_i & (wb_rd_i != '0) & (wb_rd_i == src_i);
      if (mem_hit) begin
         sel_o = FWD_EXMEM;
      end else if (wb_hit) begin
         sel_o = FWD_MEMWB;
      end
   end

endmodule : mips_fwd_mux_sel

// File: rtl/mips_pipe_hazard_unit.sv
// mips_pipe_hazard_unit: stall / flush / forwarding control for the 5-stage
// MIPS pipe, with a hold of the whole pipe while data memory is busy.
//   clk, rst      clock, asynchronous active-low reset
//   hz (slave)    ID/EX operand info, br_taken, dmem_ack in;
//                 dmem_req, stall_if/id, flush_if_id/id_ex, fwd_a/b_sel,
//                 pipe_frozen out
// Parameters: REG_ADDR_W, BR_STAGE (1 = branch resolved in ID, 2 = in EX).
// Optional macro HAZ_PERF_CNT_EN adds CNT_W-bit stall_cnt / flush_cnt.
module mips_pipe_hazard_unit
   import mips_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int unsigned BR_STAGE   = 1
`ifdef HAZ_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W      = 16
`endif
) (
   input logic                     clk,
   input logic                     rst,
   mips_pipe_hazard_unit_if.slave  hz
);

   localparam logic BR_IN_EX = (BR_STAGE == 2);

   // Pipeline slot tracking (EX, MEM, WB).
   logic                  ex_vld_q, ex_regwrite_q, ex_memread_q, ex_memwrite_q;
   logic [REG_ADDR_W-1:0] ex_rd_q;
   logic                  mem_vld_q, mem_regwrite_q, mem_memread_q, mem_memwrite_q;
   logic [REG_ADDR_W-1:0] mem_rd_q;
   logic                  wb_vld_q, wb_regwrite_q;
   logic [REG_ADDR_W-1:0] wb_rd_q;

   hz_state_e state_q, state_d;

   logic mem_op_c;
   logic hold_c;
   logic load_use_c;
   logic br_flush_c;
   logic stall_c;
   logic flush_id_ex_c;
   logic [FWD_SEL_W-1:0] fwd_a_c, fwd_b_c;

   // Hazard detection; a pending memory op blocks every advance and flush.
   always_comb begin
      mem_op_c      = mem_vld_q & (mem_memread_q | mem_memwrite_q);
      hold_c        = mem_op_c & ~hz.dmem_ack;
      load_use_c    = ex_vld_q & ex_memread_q & (ex_rd_q != '0) &
                      ((hz.id_uses_rs & (hz.id_rs == ex_rd_q)) |
                       (hz.id_uses_rt & (hz.id_rt == ex_rd_q)));
      br_flush_c    = hz.br_taken & ~hold_c;
      // A taken branch discards the dependent instruction, so no stall is needed.
      stall_c       = hold_c | (load_use_c & ~br_flush_c);
      flush_id_ex_c = ~hold_c & (load_use_c | (BR_IN_EX & hz.br_taken));
   end

   // Memory-wait FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:      if (hold_c)  state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: if (!hold_c) state_d = ST_RUN;
         default:     state_d = ST_RUN;
      endcase
   end

   // State register and slot advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_RUN;
         ex_vld_q       <= 1'b0;
         ex_regwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         ex_memwrite_q  <= 1'b0;
         ex_rd_q        <= '0;
         mem_vld_q      <= 1'b0;
         mem_regwrite_q <= 1'b0;
         mem_memread_q  <= 1'b0;
         mem_memwrite_q <= 1'b0;
         mem_rd_q       <= '0;
         wb_vld_q       <= 1'b0;
         wb_regwrite_q  <= 1'b0;
         wb_rd_q        <= '0;
      end else begin
         state_q <= state_d;
         if (!hold_c) begin
            ex_vld_q       <= hz.id_valid & ~stall_c & ~flush_id_ex_c;
            ex_regwrite_q  <= hz.id_regwrite;
            ex_memread_q   <= hz.id_memread;
            ex_memwrite_q  <= hz.id_memwrite;
            ex_rd_q        <= hz.id_rd;
            mem_vld_q      <= ex_vld_q;
            mem_regwrite_q <= ex_regwrite_q;
            mem_memread_q  <= ex_memread_q;
            mem_memwrite_q <= ex_memwrite_q;
            mem_rd_q       <= ex_rd_q;
            wb_vld_q       <= mem_vld_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_rd_q        <= mem_rd_q;
         end
      end
   end

   mips_fwd_mux_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .src_i          (hz.ex_rs),
      .mem_vld_i      (mem_vld_q),
      .mem_regwrite_i (mem_regwrite_q),
      .mem_rd_i       (mem_rd_q),
      .wb_vld_i       (wb_vld_q),
      .wb_regwrite_i  (wb_regwrite_q),
      .wb_rd_i        (wb_rd_q),
      .sel_o          (fwd_a_c)
   );

   mips_fwd_mux_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .src_i          (hz.ex_rt),
      .mem_vld_i      (mem_vld_q),
      .mem_regwrite_i (mem_regwrite_q),
      .mem_rd_i       (mem_rd_q),
      .wb_vld_i       (wb_vld_q),
      .wb_regwrite_i  (wb_regwrite_q),
      .wb_rd_i        (wb_rd_q),
      .sel_o          (fwd_b_c)
   );

   // Outputs forced low while reset is applied, independent of inputs.
   assign hz.dmem_req    = mem_op_c;
   assign hz.pipe_frozen = rst & hold_c;
   assign hz.stall_if    = rst & stall_c;
   assign hz.stall_id    = rst & stall_c;
   assign hz.flush_if_id = rst & br_flush_c;
   assign hz.flush_id_ex = rst & flush_id_ex_c;
   assign hz.fwd_a_sel   = fwd_a_c;
   assign hz.fwd_b_sel   = fwd_b_c;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (br_flush_c && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule : mips_pipe_hazard_unit

// File: tb/tb_mips_pipe_hazard_unit.sv
// tb_mips_pipe_hazard_unit: directed bench for mips_pipe_hazard_unit.
// Two instances share all stimulus: u_dut1 (BR_STAGE=1) and u_dut2
// (BR_STAGE=2). Counter checks are compiled in with HAZ_PERF_CNT_EN.
module tb_mips_pipe_hazard_unit;
   import mips_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   mips_pipe_hazard_unit_if #(.REG_ADDR_W(5)) u_if1 ();
   mips_pipe_hazard_unit_if #(.REG_ADDR_W(5)) u_if2 ();

   mips_pipe_hazard_unit #(.REG_ADDR_W(5), .BR_STAGE(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .hz  (u_if1.slave)
   );

   mips_pipe_hazard_unit #(.REG_ADDR_W(5), .BR_STAGE(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .hz  (u_if2.slave)
   );

   assign u_if2.id_valid    = u_if1.id_valid;
   assign u_if2.id_rs       = u_if1.id_rs;
   assign u_if2.id_rt       = u_if1.id_rt;
   assign u_if2.id_uses_rs  = u_if1.id_uses_rs;
   assign u_if2.id_uses_rt  = u_if1.id_uses_rt;
   assign u_if2.id_rd       = u_if1.id_rd;
   assign u_if2.id_regwrite = u_if1.id_regwrite;
   assign u_if2.id_memread  = u_if1.id_memread;
   assign u_if2.id_memwrite = u_if1.id_memwrite;
   assign u_if2.ex_rs       = u_if1.ex_rs;
   assign u_if2.ex_rt       = u_if1.ex_rt;
   assign u_if2.br_taken    = u_if1.br_taken;
   assign u_if2.dmem_ack    = u_if1.dmem_ack;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_s(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_n(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw);
      u_if1.id_valid    = v;
      u_if1.id_rs       = rs;
      u_if1.id_rt       = rt;
      u_if1.id_uses_rs  = urs;
      u_if1.id_uses_rt  = urt;
      u_if1.id_rd       = rd;
      u_if1.id_regwrite = rw;
      u_if1.id_memread  = mr;
      u_if1.id_memwrite = mw;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      idle();
      u_if1.ex_rs    = 5'd0;
      u_if1.ex_rt    = 5'd0;
      u_if1.br_taken = 1'b1;
      u_if1.dmem_ack = 1'b0;

      // Reset: outputs low even with br_taken asserted.
      #3;
      chk_b("rst_flush_if_id", u_if1.flush_if_id, 1'b0);
      chk_b("rst_flush_id_ex2", u_if2.flush_id_ex, 1'b0);
      chk_b("rst_stall_id", u_if1.stall_id, 1'b0);
      chk_b("rst_dmem_req", u_if1.dmem_req, 1'b0);
      chk_b("rst_frozen", u_if1.pipe_frozen, 1'b0);
      chk_s("rst_fwd_a", u_if1.fwd_a_sel, 2'b00);
`ifdef HAZ_PERF_CNT_EN
      chk_n("rst_stall_cnt", 16'(u_if1.stall_cnt), 16'd0);
`endif
      u_if1.br_taken = 1'b0;
      #9 rst = 1'b1;
      next();

      // C1: lw $2 in ID
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk_b("c1_stall_id", u_if1.stall_id, 1'b0);
      chk_b("c1_flush_id_ex", u_if1.flush_id_ex, 1'b0);
      next();

      // C2: add $4,$2,$5 behind the load -> load-use
      set_id(1'b1, 5'd2, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk_b("lu_stall_if", u_if1.stall_if, 1'b1);
      chk_b("lu_stall_id", u_if1.stall_id, 1'b1);
      chk_b("lu_flush_id_ex", u_if1.flush_id_ex, 1'b1);
      chk_b("lu_flush_if_id", u_if1.flush_if_id, 1'b0);
      chk_b("lu_dmem_req", u_if1.dmem_req, 1'b0);
      next();

      // C3: add still in ID, lw in MEM acked same cycle
      u_if1.dmem_ack = 1'b1;
      @(negedge clk);
      chk_b("lu2_stall_id", u_if1.stall_id, 1'b0);
      chk_b("lu2_flush_id_ex", u_if1.flush_id_ex, 1'b0);
      chk_b("lu2_dmem_req", u_if1.dmem_req, 1'b1);
      chk_b("lu2_frozen", u_if1.pipe_frozen, 1'b0);
      next();

      // C4: add in EX, lw in WB
      idle();
      u_if1.dmem_ack = 1'b0;
      u_if1.ex_rs = 5'd2;
      u_if1.ex_rt = 5'd5;
      @(negedge clk);
      chk_s("lu_fwd_a_wb", u_if1.fwd_a_sel, 2'b10);
      chk_s("lu_fwd_b_rf", u_if1.fwd_b_sel, 2'b00);
      chk_b("c4_dmem_req", u_if1.dmem_req, 1'b0);
      next();

      // C5: add4 in MEM
      set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
      u_if1.ex_rs = 5'd4;
      u_if1.ex_rt = 5'd0;
      @(negedge clk);
      chk_s("c5_fwd_a_mem", u_if1.fwd_a_sel, 2'b01);
      chk_s("c5_fwd_b_r0", u_if1.fwd_b_sel, 2'b00);
      next();

      // C6: add4 in WB
      u_if1.ex_rt = 5'd4;
      @(negedge clk);
      chk_s("c6_fwd_a_wb", u_if1.fwd_a_sel, 2'b10);
      chk_s("c6_fwd_b_wb", u_if1.fwd_b_sel, 2'b10);
      next();

      // C7: sub $6,$3,$3 in ID; first add $3 in MEM
      set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      u_if1.ex_rs = 5'd3;
      u_if1.ex_rt = 5'd0;
      @(negedge clk);
      chk_b("c7_no_stall", u_if1.stall_id, 1'b0);
      chk_s("c7_fwd_a_mem", u_if1.fwd_a_sel, 2'b01);
      next();

      // C8: $3 in both MEM and WB -> EX/MEM priority
      idle();
      u_if1.ex_rt = 5'd3;
      @(negedge clk);
      chk_s("prio_fwd_a", u_if1.fwd_a_sel, 2'b01);
      chk_s("prio_fwd_b", u_if1.fwd_b_sel, 2'b01);
      next();

      // C9: sub6 in MEM, add3 in WB
      u_if1.ex_rt = 5'd6;
      @(negedge clk);
      chk_s("c9_fwd_a_wb", u_if1.fwd_a_sel, 2'b10);
      chk_s("c9_fwd_b_mem", u_if1.fwd_b_sel, 2'b01);
      next();

      // C10: write to $0 enters ID; sub6 in WB
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      u_if1.ex_rs = 5'd0;
      @(negedge clk);
      chk_s("c10_fwd_a", u_if1.fwd_a_sel, 2'b00);
      chk_s("c10_fwd_b_wb", u_if1.fwd_b_sel, 2'b10);
      next();

      // C11..C13: $0 writer through MEM and WB never forwards
      idle();
      u_if1.ex_rt = 5'd0;
      next();
      @(negedge clk);
      chk_s("r0_mem_fwd_a", u_if1.fwd_a_sel, 2'b00);
      chk_s("r0_mem_fwd_b", u_if1.fwd_b_sel, 2'b00);
      next();
      @(negedge clk);
      chk_s("r0_wb_fwd_a", u_if1.fwd_a_sel, 2'b00);
      next();

      // C14: lw $2 again
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
      next();

      // C15: load-use plus taken branch -> flush wins
      set_id(1'b1, 5'd2, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      u_if1.br_taken = 1'b1;
      @(negedge clk);
      chk_b("brlu2_flush_if_id", u_if2.flush_if_id, 1'b1);
      chk_b("brlu2_flush_id_ex", u_if2.flush_id_ex, 1'b1);
      chk_b("brlu2_stall_id", u_if2.stall_id, 1'b0);
      chk_b("brlu2_stall_if", u_if2.stall_if, 1'b0);
      chk_b("brlu1_stall_id", u_if1.stall_id, 1'b0);
      chk_b("brlu1_flush_if_id", u_if1.flush_if_id, 1'b1);
      next();

      // C16: plain taken branch, lw in MEM acked
      set_id(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      u_if1.dmem_ack = 1'b1;
      @(negedge clk);
      chk_b("br1_flush_if_id", u_if1.flush_if_id, 1'b1);
      chk_b("br1_flush_id_ex", u_if1.flush_id_ex, 1'b0);
      chk_b("br2_flush_if_id", u_if2.flush_if_id, 1'b1);
      chk_b("br2_flush_id_ex", u_if2.flush_id_ex, 1'b1);
      next();

      // C17..C19: drain; ack with no request is ignored
      idle();
      u_if1.br_taken = 1'b0;
      next();
      @(negedge clk);
      chk_b("stray_ack_req", u_if1.dmem_req, 1'b0);
      chk_b("stray_ack_frozen", u_if1.pipe_frozen, 1'b0);
      chk_b("stray_ack_stall", u_if1.stall_id, 1'b0);
      next();
      u_if1.dmem_ack = 1'b0;
      next();

      // C20: sw, C21: add $7 behind it
      set_id(1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      next();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      next();

      // C22..C24: sw in MEM, ack low for three cycles
      idle();
      u_if1.ex_rs = 5'd7;
      @(negedge clk);
      chk_b("w0_req", u_if1.dmem_req, 1'b1);
      chk_b("w0_frozen", u_if1.pipe_frozen, 1'b1);
      chk_b("w0_stall_if", u_if1.stall_if, 1'b1);
      chk_b("w0_stall_id", u_if1.stall_id, 1'b1);
      chk_s("w0_fwd_a", u_if1.fwd_a_sel, 2'b00);
      next();
      u_if1.br_taken = 1'b1;
      @(negedge clk);
      chk_b("w1_req", u_if1.dmem_req, 1'b1);
      chk_b("w1_frozen", u_if1.pipe_frozen, 1'b1);
      chk_b("w1_flush_if_id", u_if1.flush_if_id, 1'b0);
      chk_b("w1_flush_id_ex2", u_if2.flush_id_ex, 1'b0);
      next();
      u_if1.br_taken = 1'b0;
      @(negedge clk);
      chk_b("w2_frozen", u_if1.pipe_frozen, 1'b1);
      chk_s("w2_fwd_a", u_if1.fwd_a_sel, 2'b00);
      next();

      // C25: ack cycle, pipe advances
      u_if1.dmem_ack = 1'b1;
      @(negedge clk);
      chk_b("ack_req", u_if1.dmem_req, 1'b1);
      chk_b("ack_frozen", u_if1.pipe_frozen, 1'b0);
      chk_b("ack_stall_id", u_if1.stall_id, 1'b0);
      next();

      // C26: add $7 now in MEM
      u_if1.dmem_ack = 1'b0;
      @(negedge clk);
      chk_s("adv_fwd_a", u_if1.fwd_a_sel, 2'b01);
      chk_b("adv_req", u_if1.dmem_req, 1'b0);
`ifdef HAZ_PERF_CNT_EN
      chk_n("stall_cnt", 16'(u_if1.stall_cnt), 16'd4);
      chk_n("flush_cnt", 16'(u_if1.flush_cnt), 16'd2);
      chk_n("stall_cnt2", 16'(u_if2.stall_cnt), 16'd4);
`endif
      next();

      // C27..C28: sw then add $8
      set_id(1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      next();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      next();

      // C29: waiting, then reset asserted mid-cycle
      idle();
      u_if1.ex_rs = 5'd8;
      @(negedge clk);
      chk_b("pre_rst_frozen", u_if1.pipe_frozen, 1'b1);
      chk_b("pre_rst_req", u_if1.dmem_req, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk_b("arst_req", u_if1.dmem_req, 1'b0);
      chk_b("arst_frozen", u_if1.pipe_frozen, 1'b0);
      chk_b("arst_stall_id", u_if1.stall_id, 1'b0);
      chk_b("arst_stall_if", u_if1.stall_if, 1'b0);
`ifdef HAZ_PERF_CNT_EN
      chk_n("arst_stall_cnt", 16'(u_if1.stall_cnt), 16'd0);
`endif
      next();
      rst = 1'b1;
      @(negedge clk);
      chk_s("post_rst_fwd_a", u_if1.fwd_a_sel, 2'b00);
      chk_b("post_rst_req", u_if1.dmem_req, 1'b0);
      chk_b("post_rst_frozen", u_if1.pipe_frozen, 1'b0);
      next();
      @(negedge clk);
      chk_s("post_rst2_fwd_a", u_if1.fwd_a_sel, 2'b00);
      chk_b("post_rst2_frozen", u_if1.pipe_frozen, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mips_pipe_hazard_unit
